// File: rtl/fetch_unit.sv
// fetch_unit: MIPS IF stage owning the PC, the icache request and the IF/ID latch.
// Ports: CLK/nRST (sync active-low reset); ihit/imemload/iREN/imemaddr talk to the icache;
// pcsrc/pc_en_bj/pc_freeze/branch_target/jump_target/jr_target select the next PC;
// ifid_flush/ifid_freeze/halt control the IF/ID latch and the fetch state;
// pc, ifid_instr, ifid_npc and ifid_valid are the registered stage outputs.
module fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] imemaddr,
  input  logic [2:0]  pcsrc,
  input  logic        pc_en_bj,
  input  logic        pc_freeze,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] jr_target,
  input  logic        ifid_flush,
  input  logic        ifid_freeze,
  input  logic        halt,
  output logic [31:0] pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_npc,
  output logic        ifid_valid
);
  typedef enum logic [1:0] {RUN, WAIT, HALTED} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, ptgt_q, ptgt_d, instr_q, instr_d, npc_q, npc_d;
  logic        pend_q, pend_d, valid_q, valid_d;
  logic [31:0] pc_plus4, tgt;
  logic        halting, bubble, load;
  assign pc_plus4   = pc_q + 32'd4;
  assign halting    = (state_q == HALTED) || halt;
  assign imemaddr   = pc_q;
  assign iREN       = state_q != HALTED;
  assign pc         = pc_q;
  assign ifid_instr = instr_q;
  assign ifid_npc   = npc_q;
  assign ifid_valid = valid_q;
  always_comb begin
    tgt = pcsrc == 3'd1 ? branch_target :
          pcsrc == 3'd2 ? jump_target   :
          pcsrc == 3'd3 ? jr_target     : pc_plus4;
    state_d = halting ? HALTED : ihit ? RUN : WAIT;
    pc_d = halting              ? pc_q     :
           pc_en_bj             ? tgt      :
           (pend_q && ihit)     ? ptgt_q   :
           pc_freeze            ? pc_q     :
           ihit                 ? pc_plus4 : pc_q;
    // A redirect during a miss leaves the old fetch in flight; remember it so
    // the instruction it returns is dropped and the fetch is reissued.
    pend_d = halting ? pend_q : pc_en_bj ? !ihit : pend_q && !ihit;
    ptgt_d = (!halting && pc_en_bj && !ihit) ? tgt : ptgt_q;
    bubble  = halting || ifid_flush;
    load    = ihit && !pend_q && !pc_freeze;
    instr_d = bubble ? 32'h0 : ifid_freeze ? instr_q : load ? imemload : 32'h0;
    npc_d   = bubble ? 32'h0 : ifid_freeze ? npc_q   : load ? pc_plus4 : 32'h0;
    valid_d = bubble ? 1'b0  : ifid_freeze ? valid_q : load;
  end
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= RUN;
      pc_q    <= PC_INIT;
      pend_q  <= 1'b0;
      ptgt_q  <= 32'h0;
      instr_q <= 32'h0;
      npc_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      ptgt_q  <= ptgt_d;
      instr_q <= instr_d;
      npc_q   <= npc_d;
      valid_q <= valid_d;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven self-checking bench for fetch_unit.
module tb_fetch_unit;
  logic        CLK = 0, nRST = 0, ihit = 0, pc_en_bj = 0, pc_freeze = 0;
  logic        ifid_flush = 0, ifid_freeze = 0, halt = 0, iREN, ifid_valid;
  logic [2:0]  pcsrc = 0;
  logic [31:0] imemload = 0, branch_target = 0, jump_target = 0, jr_target = 0;
  logic [31:0] imemaddr, pc, ifid_instr, ifid_npc;
  int checks = 0, failures = 0;

  fetch_unit #(.PC_INIT(32'h0)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload), .iREN(iREN),
    .imemaddr(imemaddr), .pcsrc(pcsrc), .pc_en_bj(pc_en_bj), .pc_freeze(pc_freeze),
    .branch_target(branch_target), .jump_target(jump_target), .jr_target(jr_target),
    .ifid_flush(ifid_flush), .ifid_freeze(ifid_freeze), .halt(halt), .pc(pc),
    .ifid_instr(ifid_instr), .ifid_npc(ifid_npc), .ifid_valid(ifid_valid)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic nrst, ihit; logic [31:0] imem; logic [2:0] pcsrc;
    logic bj, pcf, flush, frz, halt; logic [31:0] br, j, jr;
    logic [31:0] e_pc, e_instr, e_npc; logic e_valid, e_iren;
  } vec_t;
  vec_t vq[$];

  task automatic add(input logic nrst, ih, input logic [31:0] im, input logic [2:0] ps,
                     input logic bj, pcf, fl, fz, hl, input logic [31:0] br, j, jr,
                     input logic [31:0] epc, ein, enpc, input logic ev, eir);
    vec_t v;
    v = '{nrst, ih, im, ps, bj, pcf, fl, fz, hl, br, j, jr, epc, ein, enpc, ev, eir};
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step(input vec_t v);
    @(negedge CLK);
    nRST = v.nrst; ihit = v.ihit; imemload = v.imem; pcsrc = v.pcsrc; pc_en_bj = v.bj;
    pc_freeze = v.pcf; ifid_flush = v.flush; ifid_freeze = v.frz; halt = v.halt;
    branch_target = v.br; jump_target = v.j; jr_target = v.jr;
    @(posedge CLK); #1;
  endtask

  task automatic chk_all(input int r, input vec_t v);
    string s;
    s = $sformatf("row%0d", r);
    chk({s, ".pc"}, pc, v.e_pc);
    chk({s, ".imemaddr"}, imemaddr, v.e_pc);
    chk({s, ".instr"}, ifid_instr, v.e_instr);
    chk({s, ".npc"}, ifid_npc, v.e_npc);
    chk({s, ".valid"}, {31'h0, ifid_valid}, {31'h0, v.e_valid});
    chk({s, ".iREN"}, {31'h0, iREN}, {31'h0, v.e_iren});
  endtask

  initial begin
    vec_t h;
    // nrst ihit imem pcsrc bj pcf flush frz halt br j jr | pc instr npc valid iren
    add(0,0,0,0,0,0,0,0,0, 'h100,'h200,0, 0,0,0,0,1);
    add(1,1,'h20010001,0,0,0,0,0,0, 'h100,'h200,0, 4,'h20010001,4,1,1);
    add(1,1,'h20020002,0,0,0,0,0,0, 'h100,'h200,0, 8,'h20020002,8,1,1);
    add(1,1,'h20030003,0,0,0,0,0,0, 'h100,'h200,0, 'hC,'h20030003,'hC,1,1);
    add(1,1,'h0badf00d,3,1,0,1,0,0, 'h100,'h200,'h40, 'h40,0,0,0,1);
    add(1,1,'hdeadbeef,1,1,0,1,0,0, 'h100,'h200,'h999, 'h100,0,0,0,1);
    add(1,1,'h11111111,3,1,0,0,0,0, 'h100,'h200,'h80, 'h80,'h11111111,'h104,1,1);
    add(1,0,'h0,0,0,0,0,0,0, 'h100,'h200,0, 'h80,0,0,0,1);
    add(1,0,'h0,2,1,0,0,0,0, 'h100,'h200,'h999, 'h200,0,0,0,1);
    add(1,0,'h0,0,0,0,0,0,0, 'h100,'h200,0, 'h200,0,0,0,1);
    add(1,0,'h0,0,0,0,0,0,0, 'h100,'h200,0, 'h200,0,0,0,1);
    add(1,1,'h22222222,0,0,0,0,0,0, 'h100,'h200,0, 'h200,0,0,0,1);
    add(1,1,'h33333333,0,0,0,0,0,0, 'h100,'h200,0, 'h204,'h33333333,'h204,1,1);
    add(1,1,'h44444444,3,1,0,0,0,0, 'h100,'h200,'h10, 'h10,'h44444444,'h208,1,1);
    add(1,1,'h55555555,0,0,1,0,1,0, 'h100,'h200,0, 'h10,'h44444444,'h208,1,1);
    add(1,1,'h55555555,0,0,1,0,1,0, 'h100,'h200,0, 'h10,'h44444444,'h208,1,1);
    add(1,1,'h66666666,0,0,0,0,0,0, 'h100,'h200,0, 'h14,'h66666666,'h14,1,1);
    add(1,1,'h77777777,0,0,1,0,0,0, 'h100,'h200,0, 'h14,0,0,0,1);
    add(1,1,'h88888888,1,1,0,0,0,0, 'h30,'h200,0, 'h30,'h88888888,'h18,1,1);
    add(1,1,'h99999999,1,1,0,0,0,1, 'h500,'h200,0, 'h30,0,0,0,0);
    for (int i = 0; i < 9; i++)
      add(1,1,'haaaa0000,2,1,0,0,0,0, 'h100,'h600,0, 'h30,0,0,0,0);
    add(0,1,'h12121212,0,0,0,0,0,0, 'h100,'h200,0, 0,0,0,0,1);
    add(1,1,'h0,3,1,0,1,0,0, 'h100,'h200,'hFFFFFFFC, 'hFFFFFFFC,0,0,0,1);
    add(1,1,'hAAAAAAAA,0,0,0,0,0,0, 'h100,'h200,0, 0,'hAAAAAAAA,0,1,1);
    add(1,1,'hBBBBBBBB,5,1,0,0,0,0, 'h100,'h200,'h900, 4,'hBBBBBBBB,4,1,1);
    add(1,0,'h0,0,0,0,0,0,0, 'h100,'h200,0, 4,0,0,0,1);
    add(0,0,'h0,0,0,0,0,0,0, 'h100,'h200,0, 0,0,0,0,1);
    add(1,1,'hCCCCCCCC,0,0,0,0,0,0, 'h100,'h200,0, 4,'hCCCCCCCC,4,1,1);
    add(1,0,'h0,0,0,0,0,0,0, 'h100,'h200,0, 4,0,0,0,1);
    add(1,0,'h0,1,1,0,0,0,0, 'h100,'h200,0, 'h100,0,0,0,1);
    add(1,0,'h0,2,1,0,0,0,0, 'h100,'h200,0, 'h200,0,0,0,1);
    add(1,1,'hDDDDDDDD,0,0,0,0,0,0, 'h100,'h200,0, 'h200,0,0,0,1);
    add(1,1,'hEEEEEEEE,0,0,0,0,0,0, 'h100,'h200,0, 'h204,'hEEEEEEEE,'h204,1,1);
    add(1,0,'h0,0,0,0,0,0,0, 'h100,'h200,0, 'h204,0,0,0,1);
    add(1,0,'h0,0,0,0,0,0,1, 'h100,'h200,0, 'h204,0,0,0,0);
    add(1,1,'hFFFF0000,0,0,0,0,0,0, 'h100,'h200,0, 'h204,0,0,0,0);
    for (int r = 0; r < vq.size(); r++) begin
      step(vq[r]);
      chk_all(r, vq[r]);
    end
    // IF/ID freeze holds across a miss, and flush outranks freeze.
    h = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
    step(h);
    h.nrst = 1; h.ihit = 1; h.imem = 32'h12345678;
    step(h);
    chk("seq.load", ifid_instr, 32'h12345678);
    h.ihit = 0; h.frz = 1;
    step(h);
    chk("seq.hold_instr", ifid_instr, 32'h12345678);
    chk("seq.hold_npc", ifid_npc, 32'h4);
    chk("seq.hold_pc", pc, 32'h4);
    h.flush = 1;
    step(h);
    chk("seq.flush_instr", ifid_instr, 32'h0);
    chk("seq.flush_valid", {31'h0, ifid_valid}, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
